// File: rtl/inst_sram_resp_pkg.sv
// Shared definitions for the inst_sram responder: segment translation,
// FSM encodings and the request bundle.
package inst_sram_resp_pkg;

    localparam logic [31:0] KSEG_MASK     = 32'h1fff_ffff;
    localparam logic [1:0]  KSEG_SEL      = 2'b10;
    localparam int          RESP_WAIT_MAX = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    // kseg0/kseg1 fold onto the low 512 MB; everything else passes through
    function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
        return (va[31:30] == KSEG_SEL) ? (va & KSEG_MASK) : va;
    endfunction

endpackage

// File: rtl/inst_sram_resp_sram_byte_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port whose output register can be reset or cleared.
module sram_byte_array #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) rdata <= 32'h0;
        else if (re)    rdata <= mem[idx];
    end

endmodule

// File: rtl/inst_sram_resp.sv
// Responder end of the inst_sram interface: address translation, window
// check, optional read wait states and the pipeline stall request.
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [31:0] BASE_PADDR  = 32'h1fc0_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        stallreq,
    output logic        addr_err
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    sram_req_t             req;
    logic [31:0]           paddr;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_window;
    logic                  aligned;
    logic                  valid;
    logic                  accept;
    logic                  is_rd;
    logic                  is_wr;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] pend_idx;

    logic                  arr_re;
    logic                  arr_clr;
    logic [3:0]            arr_we;
    logic [ADDR_WIDTH-1:0] arr_idx;

    assign req       = '{inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata};
    assign paddr     = kseg_xlate(req.addr);
    assign idx       = paddr[ADDR_WIDTH+1:2];
    assign in_window = (paddr[31:ADDR_WIDTH+2] == BASE_PADDR[31:ADDR_WIDTH+2]);
    assign aligned   = (paddr[1:0] == 2'b00);
    assign valid     = in_window && aligned;

    // the pipeline holds its request while we stall, so WAIT ignores en
    assign accept = req.en && (state != ST_WAIT);
    assign is_rd  = accept && (req.wen == 4'h0);
    assign is_wr  = accept && (req.wen != 4'h0);

    assign stallreq = (state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 3'd0;
            pend_idx <= '0;
            addr_err <= 1'b0;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= ST_RESP;
        end else if (!req.en) begin
            state <= ST_IDLE;
        end else begin
            addr_err <= !valid;
            if (req.wen == 4'h0) begin
                if (valid && WAIT_CYCLES != 0) begin
                    state    <= ST_WAIT;
                    cnt      <= WAIT_INIT;
                    pend_idx <= idx;
                end else begin
                    state <= ST_RESP;
                end
            end
        end
    end

    // a delayed read fetches from the index captured at acceptance
    assign arr_re  = (is_rd && valid && WAIT_CYCLES == 0) ||
                     (state == ST_WAIT && cnt == 3'd1);
    assign arr_clr = is_rd && !valid;
    assign arr_we  = (is_wr && valid && !rst) ? req.wen : 4'h0;
    assign arr_idx = (state == ST_WAIT) ? pend_idx : idx;

    sram_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .clr  (arr_clr),
        .re   (arr_re),
        .we   (arr_we),
        .idx  (arr_idx),
        .wdata(req.wdata),
        .rdata(inst_sram_rdata)
    );

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: vector table and random run on a zero-wait
// instance, hand sequences for wait states and reset during WAIT.
module tb_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1fc0_0000;
    localparam logic [31:0] WSZ  = 32'h0001_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, rst3, en3, rst5, en5;
    logic [3:0]  wen0, wen3, wen5;
    logic [31:0] addr0, wd0, addr3, wd3, addr5, wd5;
    logic [31:0] rd0, rd3, rd5;
    logic        st0, st3, st5, er0, er3, er5;

    inst_sram_resp #(.WAIT_CYCLES(0)) d0 (
        .clk(clk), .rst(rst0), .inst_sram_en(en0), .inst_sram_wen(wen0),
        .inst_sram_addr(addr0), .inst_sram_wdata(wd0), .inst_sram_rdata(rd0),
        .stallreq(st0), .addr_err(er0));
    inst_sram_resp #(.WAIT_CYCLES(3)) d3 (
        .clk(clk), .rst(rst3), .inst_sram_en(en3), .inst_sram_wen(wen3),
        .inst_sram_addr(addr3), .inst_sram_wdata(wd3), .inst_sram_rdata(rd3),
        .stallreq(st3), .addr_err(er3));
    inst_sram_resp #(.WAIT_CYCLES(5)) d5 (
        .clk(clk), .rst(rst5), .inst_sram_en(en5), .inst_sram_wen(wen5),
        .inst_sram_addr(addr5), .inst_sram_wdata(wd5), .inst_sram_rdata(rd5),
        .stallreq(st5), .addr_err(er5));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[14];

    // spec-level model for the random run
    logic [31:0] m [int];

    function automatic logic [31:0] to_pa(input logic [31:0] va);
        return (va >> 30) == 32'd2 ? (va & 32'h1fff_ffff) : va;
    endfunction

    function automatic logic ok_addr(input logic [31:0] va);
        logic [31:0] pa;
        pa = to_pa(va);
        return (pa >= BASE) && (pa < BASE + WSZ) && (va % 4 == 0);
    endfunction

    initial begin
        logic [31:0] exp_rd, tmp, a;
        logic        exp_err;
        int          n;

        rst0 = 1; rst3 = 1; rst5 = 1;
        en0 = 0; en3 = 0; en5 = 0;
        wen0 = 0; wen3 = 0; wen5 = 0;
        addr0 = 0; addr3 = 0; addr5 = 0;
        wd0 = 0; wd3 = 0; wd5 = 0;
        step(); step();
        chk("rst rdata0", rd0, 0); chk("rst stall0", {31'd0, st0}, 0); chk("rst err0", {31'd0, er0}, 0);
        chk("rst rdata3", rd3, 0); chk("rst stall3", {31'd0, st3}, 0); chk("rst err3", {31'd0, er3}, 0);
        chk("rst rdata5", rd5, 0); chk("rst stall5", {31'd0, st5}, 0); chk("rst err5", {31'd0, er5}, 0);
        rst0 = 0; rst3 = 0; rst5 = 0;

        // ---- vector table, zero wait states ----
        vt[0]  = '{4'hf, 32'hbfc0_0000, 32'h2408_0001, 32'h0000_0000, 1'b0};
        vt[1]  = '{4'h0, 32'hbfc0_0000, 32'h0,         32'h2408_0001, 1'b0};
        vt[2]  = '{4'hf, 32'h9fc0_0010, 32'h0,         32'h2408_0001, 1'b0};
        vt[3]  = '{4'h3, 32'h9fc0_0010, 32'haabb_ccdd, 32'h2408_0001, 1'b0};
        vt[4]  = '{4'h0, 32'h9fc0_0010, 32'h0,         32'h0000_ccdd, 1'b0};
        vt[5]  = '{4'h0, 32'hbfc0_0002, 32'h0,         32'h0000_0000, 1'b1};
        vt[6]  = '{4'h0, 32'hbfc1_0000, 32'h0,         32'h0000_0000, 1'b1};
        vt[7]  = '{4'hf, 32'hbfc0_fffc, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vt[8]  = '{4'h0, 32'hbfc0_fffc, 32'h0,         32'h1234_5678, 1'b0};
        vt[9]  = '{4'hf, 32'hbfc1_0000, 32'hdead_beef, 32'h1234_5678, 1'b1};
        vt[10] = '{4'h0, 32'h1fc0_fffc, 32'h0,         32'h1234_5678, 1'b0};
        vt[11] = '{4'h0, 32'h3fc0_0000, 32'h0,         32'h0000_0000, 1'b1};
        vt[12] = '{4'hf, 32'hbfc0_0001, 32'hffff_ffff, 32'h0000_0000, 1'b1};
        vt[13] = '{4'h0, 32'hbfc0_0000, 32'h0,         32'h2408_0001, 1'b0};
        for (int i = 0; i < 14; i++) begin
            en0 = 1; wen0 = vt[i].wen; addr0 = vt[i].addr; wd0 = vt[i].wdata;
            step();
            chk($sformatf("vec%0d rdata", i), rd0, vt[i].exp_rd);
            chk($sformatf("vec%0d err", i), {31'd0, er0}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d stall", i), {31'd0, st0}, 0);
        end
        en0 = 0;
        step(); step();
        chk("idle hold rdata", rd0, 32'h2408_0001);
        chk("idle hold err", {31'd0, er0}, 0);

        // ---- random run against model ----
        for (int i = 0; i < 16; i++) begin
            en0 = 1; wen0 = 4'hf; addr0 = 32'hbfc0_0000 + i * 4; wd0 = $urandom;
            m[i] = wd0;
            step();
        end
        exp_rd = rd0;
        exp_err = 1'b0;
        for (int it = 0; it < 300; it++) begin
            int sel, ix;
            en0 = ($urandom_range(0, 3) != 0);
            wen0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            ix = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            case (sel)
                0: addr0 = 32'hbfc0_0000 + ix * 4 + $urandom_range(1, 3);
                1: addr0 = 32'hbfc1_0000 + ix * 4;
                2: addr0 = 32'h9fc0_0000 + ix * 4;
                3: addr0 = 32'h1fc0_0000 + ix * 4;
                4: addr0 = 32'h5fc0_0000 + ix * 4;
                default: addr0 = 32'hbfc0_0000 + ix * 4;
            endcase
            wd0 = $urandom;
            step();
            if (en0) begin
                exp_err = !ok_addr(addr0);
                a = (to_pa(addr0) - BASE) / 4;
                if (wen0 != 0) begin
                    if (!exp_err) begin
                        tmp = m[int'(a)];
                        for (int b = 0; b < 4; b++)
                            if (wen0[b]) tmp[8*b +: 8] = wd0[8*b +: 8];
                        m[int'(a)] = tmp;
                    end
                end else begin
                    exp_rd = exp_err ? 32'h0 : m[int'(a)];
                end
            end
            chk($sformatf("rnd%0d rdata", it), rd0, exp_rd);
            chk($sformatf("rnd%0d err", it), {31'd0, er0}, {31'd0, exp_err});
            chk($sformatf("rnd%0d stall", it), {31'd0, st0}, 0);
        end
        en0 = 0;

        // ---- three wait states, request changes during WAIT ----
        en3 = 1; wen3 = 4'hf; addr3 = 32'hbfc0_0000; wd3 = 32'h0bad_0000;
        step();
        chk("w3 write no stall", {31'd0, st3}, 0);
        addr3 = 32'hbfc0_0004; wd3 = 32'hcafe_0003;
        step();
        wen3 = 4'h0; addr3 = 32'hbfc0_0004;
        step();
        chk("w3 stall after accept", {31'd0, st3}, 1);
        addr3 = 32'hbfc0_0000; wen3 = 4'hf; wd3 = 32'h1111_1111;
        n = 1;
        step();
        while (st3 && n < 20) begin
            chk("w3 rdata during wait", rd3, 0);
            n++;
            step();
        end
        en3 = 0;
        chk("w3 stall cycles", n, 3);
        chk("w3 rdata at drop", rd3, 32'hcafe_0003);
        chk("w3 err", {31'd0, er3}, 0);
        step();
        en3 = 1; wen3 = 4'h0; addr3 = 32'hbfc0_0000;
        step();
        en3 = 0;
        n = 1;
        while (st3 && n < 20) begin n++; step(); end
        chk("w3 ignored write", rd3, 32'h0bad_0000);
        chk("w3 stall cycles 2", n, 4);

        // ---- five wait states, reset in the 2nd WAIT cycle ----
        en5 = 1; wen5 = 4'hf; addr5 = 32'hbfc0_0008; wd5 = 32'h5555_aaaa;
        step();
        wen5 = 4'h0;
        step();
        chk("w5 stall", {31'd0, st5}, 1);
        step();
        rst5 = 1;
        step();
        rst5 = 0;
        chk("w5 rst stall", {31'd0, st5}, 0);
        chk("w5 rst rdata", rd5, 0);
        chk("w5 rst err", {31'd0, er5}, 0);
        step();
        chk("w5 idle after rst", {31'd0, st5}, 1);
        en5 = 0;
        n = 1;
        step();
        while (st5 && n < 20) begin n++; step(); end
        chk("w5 stall cycles", n, 5);
        chk("w5 rdata", rd5, 32'h5555_aaaa);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
